// File: rtl/decode_operand_if.sv
// Bundles the decode/operand stage's FD, RegisterFile, writeback and DE signals.
// slave is the stage's view and master is the surrounding pipeline's view.
interface decode_operand_if #(
  parameter int REG_COUNT    = 16,
  parameter int REG_SIZE     = 8,
  parameter int REG_PTR_SIZE = 4
);
  logic                    FD_valid;
  logic                    FD_ready;
  logic [REG_PTR_SIZE-1:0] FD_insn_src_0, FD_insn_src_1, FD_insn_src_2;
  logic [2:0]              FD_src_used;
  logic [REG_PTR_SIZE-1:0] FD_insn_dst;
  logic                    FD_insn_writes;
  logic [REG_PTR_SIZE-1:0] RF_src_0_ptr, RF_src_1_ptr, RF_src_2_ptr;
  logic [REG_SIZE-1:0]     RF_src_0_data, RF_src_1_data, RF_src_2_data;
  logic                    MW_wr_en;
  logic [REG_PTR_SIZE-1:0] MW_wr_ptr;
  logic [REG_SIZE-1:0]     W_result;
  logic                    flush;
  logic                    DE_valid;
  logic                    DE_ready;
  logic [REG_SIZE-1:0]     DE_src_0_data, DE_src_1_data, DE_src_2_data;
  logic [REG_PTR_SIZE-1:0] DE_dst;
  logic                    DE_writes;
  logic [REG_COUNT-1:0]    pending;

  modport slave (
    input  FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2, FD_src_used,
           FD_insn_dst, FD_insn_writes, RF_src_0_data, RF_src_1_data, RF_src_2_data,
           MW_wr_en, MW_wr_ptr, W_result, flush, DE_ready,
    output FD_ready, RF_src_0_ptr, RF_src_1_ptr, RF_src_2_ptr, DE_valid,
           DE_src_0_data, DE_src_1_data, DE_src_2_data, DE_dst, DE_writes, pending
  );

  modport master (
    output FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2, FD_src_used,
           FD_insn_dst, FD_insn_writes, RF_src_0_data, RF_src_1_data, RF_src_2_data,
           MW_wr_en, MW_wr_ptr, W_result, flush, DE_ready,
    input  FD_ready, RF_src_0_ptr, RF_src_1_ptr, RF_src_2_ptr, DE_valid,
           DE_src_0_data, DE_src_1_data, DE_src_2_data, DE_dst, DE_writes, pending
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Operand fetch + RAW/WAW scoreboard feeding the DE latch under valid/ready.
// Define DECODE_OPERAND_FWD_EN to bypass the writeback result into the operands.
module decode_operand_stage #(
  parameter int REG_COUNT    = 16,
  parameter int REG_SIZE     = 8,
  parameter int REG_PTR_SIZE = 4
) (
  input logic           clk,
  input logic           reset_DO,
  decode_operand_if.slave bus
);
  typedef logic [REG_PTR_SIZE-1:0] ptr_t;
  typedef logic [REG_SIZE-1:0]     data_t;

  localparam logic [REG_PTR_SIZE:0] REG_LIMIT = (REG_PTR_SIZE + 1)'(REG_COUNT);
`ifdef DECODE_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  ptr_t                 src [3];
  data_t                rf_data [3];
  data_t                operand [3];
  logic [2:0]           clr;
  logic                 hazard, space, fd_ready, issue;

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic                 de_valid_q, de_valid_d;
  data_t                de_src_q [3];
  data_t                de_src_d [3];
  ptr_t                 de_dst_q, de_dst_d;
  logic                 de_writes_q, de_writes_d;

  // Pointers beyond the register file are never tracked.
  function automatic logic in_range(ptr_t p);
    return {1'b0, p} < REG_LIMIT;
  endfunction

  function automatic logic is_pending(logic [REG_COUNT-1:0] vec, ptr_t p);
    return in_range(p) && vec[p];
  endfunction

  assign src[0]     = bus.FD_insn_src_0;
  assign src[1]     = bus.FD_insn_src_1;
  assign src[2]     = bus.FD_insn_src_2;
  assign rf_data[0] = bus.RF_src_0_data;
  assign rf_data[1] = bus.RF_src_1_data;
  assign rf_data[2] = bus.RF_src_2_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hazard = 1'b0;
    clr    = '0;
    for (int k = 0; k < 3; k++) begin
      clr[k] = bus.MW_wr_en && (bus.MW_wr_ptr == src[k]);
      if (bus.FD_src_used[k] && is_pending(pending_q, src[k]) && !(FWD && clr[k]))
        hazard = 1'b1;
    end
    if (bus.FD_insn_writes && is_pending(pending_q, bus.FD_insn_dst) &&
        !(bus.MW_wr_en && (bus.MW_wr_ptr == bus.FD_insn_dst)))
      hazard = 1'b1;
    space    = !de_valid_q || bus.DE_ready;
    fd_ready = !hazard && space && !bus.flush;
    issue    = bus.FD_valid && fd_ready;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef DECODE_OPERAND_FWD_EN
      operand[k] = clr[k] ? bus.W_result : rf_data[k];
`else
      operand[k] = rf_data[k];
`endif
    end
  end

  // Set is applied last so it wins over a same-cycle writeback clear.
  always_comb begin
    pending_d   = pending_q;
    de_valid_d  = de_valid_q;
    de_src_d    = de_src_q;
    de_dst_d    = de_dst_q;
    de_writes_d = de_writes_q;

    if (bus.MW_wr_en && in_range(bus.MW_wr_ptr))
      pending_d[bus.MW_wr_ptr] = 1'b0;
    if (bus.flush && de_valid_q && de_writes_q && !bus.DE_ready && in_range(de_dst_q))
      pending_d[de_dst_q] = 1'b0;
    if (issue && bus.FD_insn_writes && in_range(bus.FD_insn_dst))
      pending_d[bus.FD_insn_dst] = 1'b1;

    if (issue) begin
      de_valid_d  = 1'b1;
      de_src_d    = operand;
      de_dst_d    = bus.FD_insn_dst;
      de_writes_d = bus.FD_insn_writes;
    end else if (bus.flush || bus.DE_ready) begin
      de_valid_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset_DO) begin
      pending_q   <= '0;
      de_valid_q  <= 1'b0;
      de_src_q    <= '{default: '0};
      de_dst_q    <= '0;
      de_writes_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      de_valid_q  <= de_valid_d;
      de_src_q    <= de_src_d;
      de_dst_q    <= de_dst_d;
      de_writes_q <= de_writes_d;
    end
  end

  assign bus.FD_ready      = fd_ready;
  assign bus.RF_src_0_ptr  = src[0];
  assign bus.RF_src_1_ptr  = src[1];
  assign bus.RF_src_2_ptr  = src[2];
  assign bus.DE_valid      = de_valid_q;
  assign bus.DE_src_0_data = de_src_q[0];
  assign bus.DE_src_1_data = de_src_q[1];
  assign bus.DE_src_2_data = de_src_q[2];
  assign bus.DE_dst        = de_dst_q;
  assign bus.DE_writes     = de_writes_q;
  assign bus.pending       = pending_q;
endmodule
